mul_int16_seq: RTL and testbench

MUL_INT16_SEQ -- requirements
Module: mul_int16_seq

---
 rtl/mul_pkg.sv | 13 +
 rtl/adder_nbit.sv | 12 +
 rtl/mul_int16_seq.sv | 120 ++++++++++++
 tb/tb_mul_int16_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequenced arithmetic blocks: FSM state encoding
// and the default datapath width.
package mul_pkg;

    localparam int MUL_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage : mul_pkg

// File: rtl/adder_nbit.sv
// Plain WIDTH-bit adder; the sum wraps modulo 2^WIDTH and the carry is dropped.
module adder_nbit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule : adder_nbit

// File: rtl/mul_int16_seq.sv
// Sequential shift-add multiplier: one partial product per cycle for WIDTH
// cycles, returning the low WIDTH bits of A*B over a valid/ready handshake.
module mul_int16_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
    output logic             busy
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sum_s;

    adder_nbit #(
        .WIDTH(WIDTH)
    ) u_acc_add (
        .a  (acc_q),
        .b  (mcand_q),
        .sum(sum_s)
    );

    // Next-state, datapath and handshake-flag computation.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d  = A;
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = sum_s;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                // All WIDTH steps always run, even when the multiplier empties early.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign P         = acc_q;

endmodule : mul_int16_seq

// File: tb/tb_mul_int16_seq.sv
// Scoreboard bench for mul_int16_seq: a driver queues expected products
// computed with plain integer arithmetic; a monitor checks results and protocol.
module tb_mul_int16_seq;

    localparam int W   = 16;
    localparam int LAT = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        int           acc_cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] P;
    logic         busy;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;
    int   cyc;
    bit   rand_ready;

    mul_int16_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .P        (P),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Offer one operand pair (called at a negedge); returns at the negedge after acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int   n;
        exp_t e;
        logic [31:0] prod;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout_fail("issue_wait_in_ready");
            return;
        end
        in_valid = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        @(negedge clk);
        prod      = {16'h0000, a} * {16'h0000, b};
        e.a       = a;
        e.b       = b;
        e.p       = prod[W-1:0];
        e.acc_cyc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) timeout_fail("drain");
        @(negedge clk);
    endtask

    // Random back-pressure on the result side when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: sample just after the falling edge, pop and compare on handshakes.
    initial begin
        bit           prev_stall;
        bit           prev_hs;
        bit           prev_valid;
        logic [W-1:0] prev_p;
        exp_t         e;
        prev_stall = 1'b0;
        prev_hs    = 1'b0;
        prev_valid = 1'b0;
        prev_p     = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_stall = 1'b0;
                prev_hs    = 1'b0;
                prev_valid = 1'b0;
            end else begin
                check("busy_vs_in_ready", {31'd0, busy}, {31'd0, ~in_ready});
                if (out_valid) check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
                if (prev_stall) begin
                    check("stall_out_valid_held", {31'd0, out_valid}, 32'd1);
                    check("stall_p_held", {16'd0, P}, {16'd0, prev_p});
                end
                if (prev_hs) begin
                    check("idle_after_hs_in_ready", {31'd0, in_ready}, 32'd1);
                    check("idle_after_hs_out_valid", {31'd0, out_valid}, 32'd0);
                end
                if (out_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        timeout_fail("unexpected_result");
                    end else begin
                        check("latency", cyc - sb[0].acc_cyc, LAT);
                    end
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    if (P !== e.p)
                        $display("  operands A=%0h B=%0h", e.a, e.b);
                    check("product", {16'd0, P}, {16'd0, e.p});
                end
                prev_stall = out_valid && !out_ready;
                prev_hs    = out_valid && out_ready;
                prev_valid = out_valid;
                prev_p     = P;
            end
        end
    end

    initial begin
        int n;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        out_ready  = 1'b1;

        // Reset values, including with a request pending while in reset.
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        A = 16'h1111;
        B = 16'h2222;
        @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_p", {16'd0, P}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Directed products, including truncation and a zero multiplier.
        issue(16'd3, 16'd5);
        issue(16'hFFFF, 16'hFFFF);
        issue(16'd300, 16'd300);
        issue(16'h1234, 16'h0000);
        drain();

        // Result held under back-pressure while inputs wander.
        out_ready = 1'b0;
        issue(W'($urandom), W'($urandom));
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail("wait_out_valid_stall");
        repeat (5) begin
            in_valid = 1'($urandom);
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a calculation.
        issue(16'hABCD, 16'h00FF);
        repeat (7) @(negedge clk);
        #1;
        check("busy_mid_calc", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_p", {16'd0, P}, 32'd0);
        sb.delete();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("after_abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        issue(16'd7, 16'd9);
        drain();

        // Back-to-back random traffic with random result stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 15) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 15) == 0) rb = 16'h0000;
            issue(ra, rb);
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case anything above stalls past every bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule : tb_mul_int16_seq
